// File: rtl/control_unit_if.sv
// Program-memory / datapath control bundle between the control unit and its surroundings.
// The master drives the control side (pc, decoded fields, strobes); the slave supplies instr/alu_zero.
interface control_unit_if;
  logic [7:0] instr;
  logic       alu_zero;
  logic [3:0] pc;
  logic [3:0] alu_op;
  logic [3:0] immediate;
  logic [1:0] rd_sel;
  logic [1:0] rs_sel;
  logic       reg_we;
  logic       mem_we;
  logic       halted;
  logic       fault;

  modport master (
    input  instr, alu_zero,
    output pc, alu_op, immediate, rd_sel, rs_sel, reg_we, mem_we, halted, fault
  );

  modport slave (
    output instr, alu_zero,
    input  pc, alu_op, immediate, rd_sel, rs_sel, reg_we, mem_we, halted, fault
  );
endinterface

// File: rtl/control_unit.sv
// Three-cycle FETCH/DECODE/EXECUTE sequencer with jumps, zero-flag branch and a 4-deep return stack.
// Stack over/underflow and HALT park the core in an absorbing HALT state until reset.
module control_unit (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master cu
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       zf_q, zf_d;
  logic [2:0] sp_q, sp_d;
  logic [3:0] stack_q [4];
  logic [3:0] stack_d [4];
  logic       fault_q, fault_d;

  logic [3:0] opcode;
  logic [3:0] operand;
  logic [3:0] pc_inc;
  logic [2:0] sp_dec;
  logic       ldst;

  assign opcode  = ir_q[7:4];
  assign operand = ir_q[3:0];
  assign pc_inc  = pc_q + 4'd1;
  assign sp_dec  = sp_q - 3'd1;
  assign ldst    = (opcode == 4'd9) || (opcode == 4'd10) || (opcode == 4'd11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      zf_q    <= 1'b0;
      sp_q    <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < 4; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      for (int i = 0; i < 4; i++) stack_q[i] <= stack_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zf_d    = zf_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    for (int i = 0; i < 4; i++) stack_d[i] = stack_q[i];

    unique case (state_q)
      S_FETCH: begin
        ir_d    = cu.instr;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        if (opcode <= 4'd7) zf_d = cu.alu_zero;
        case (opcode)
          4'd12: pc_d = operand;
          4'd13: if (zf_q) pc_d = operand;
          4'd14: begin
            if (sp_q == 3'd4) begin
              fault_d = 1'b1;
              pc_d    = pc_q;
              state_d = S_HALT;
            end else begin
              stack_d[sp_q[1:0]] = pc_inc;
              sp_d               = sp_q + 3'd1;
              pc_d               = operand;
            end
          end
          4'd15: begin
            // operand 0 is RET; any other operand is HALT
            if (operand != 4'd0) begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end else if (sp_q == 3'd0) begin
              fault_d = 1'b1;
              pc_d    = pc_q;
              state_d = S_HALT;
            end else begin
              pc_d = stack_q[sp_dec[1:0]];
              sp_d = sp_dec;
            end
          end
          default: ;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Decoded fields and strobes are masked while reset is held so a cut-short instruction has no effect.
  assign cu.pc        = pc_q;
  assign cu.alu_op    = reset ? 4'd0 : opcode;
  assign cu.immediate = reset ? 4'd0 : operand;
  assign cu.rd_sel    = (reset || ldst) ? 2'd0 : operand[3:2];
  assign cu.rs_sel    = (reset || ldst) ? 2'd0 : operand[1:0];
  assign cu.reg_we    = !reset && (state_q == S_EXECUTE) && (opcode <= 4'd10);
  assign cu.mem_we    = !reset && (state_q == S_EXECUTE) && (opcode == 4'd11);
  assign cu.halted    = (state_q == S_HALT);
  assign cu.fault     = fault_q;

endmodule
